// File: rtl/matrix_3x3_gen_pkg.sv
// Shared image-pipeline constants and types.
// Sync delay depth and counter-width helper for raster blocks.
package matrix_3x3_gen_pkg;

    localparam int SYNC_DLY = 2;
    localparam int WIN_N    = 3;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_3x3_gen_line_buffer.sv
// Simple dual-port line RAM with registered read.
// A same-address read and write in one cycle returns the old word.
module line_buffer
    import matrix_3x3_gen_pkg::*;
#(
    parameter int DEPTH = 500,
    parameter int DW    = 8,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding window generator over a raster stream.
// Two line buffers feed rows 1-2; the live pixel feeds row 3.
module matrix_3x3_gen
    import matrix_3x3_gen_pkg::*;
#(
    parameter int H_DISP = 500,
    parameter int V_DISP = 500,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pre_hsync,
    input  logic          pre_vsync,
    input  logic          pre_de,
    input  logic [DW-1:0] pre_data,
    output logic          post_hsync,
    output logic          post_vsync,
    output logic          post_de,
    output logic [DW-1:0] m11,
    output logic [DW-1:0] m12,
    output logic [DW-1:0] m13,
    output logic [DW-1:0] m21,
    output logic [DW-1:0] m22,
    output logic [DW-1:0] m23,
    output logic [DW-1:0] m31,
    output logic [DW-1:0] m32,
    output logic [DW-1:0] m33
);

    localparam int CW = cnt_w(H_DISP);
    localparam int RW = cnt_w(V_DISP);
    localparam logic [CW-1:0] COL_MAX = CW'(H_DISP - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(V_DISP - 1);

    sync_t         pre_sync;
    sync_t         sync_d [SYNC_DLY];
    logic          de_q;
    logic          vs_q;
    logic          vs_rise;
    logic          de_fall;
    logic          line_start;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] col_eff;
    logic [CW-1:0] addr_d1;
    logic [RW-1:0] row_cnt;
    logic [RW-1:0] row_eff;
    logic [DW-1:0] data_d1;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          first_d1;
    logic          mask1_d1;
    logic          mask2_d1;
    logic [DW-1:0] col_new [WIN_N];
    logic [DW-1:0] win [WIN_N][WIN_N];

    assign pre_sync = '{hs: pre_hsync, vs: pre_vsync, de: pre_de};

    assign vs_rise    = pre_vsync & ~vs_q;
    assign de_fall    = de_q & ~pre_de;
    assign line_start = pre_de & (~de_q | vs_rise);

    // A frame start on an active pixel pins it to row 0, column 0.
    assign col_eff = vs_rise ? '0 : col_cnt;
    assign row_eff = vs_rise ? '0 : row_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            de_q <= pre_de;
            vs_q <= pre_vsync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
        end else if (pre_de) begin
            col_cnt <= (col_eff == COL_MAX) ? COL_MAX
                                            : col_eff + CW'(1);
        end else if (de_fall) begin
            col_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
        end else if (vs_rise) begin
            row_cnt <= '0;
        end else if (de_fall && row_cnt != ROW_MAX) begin
            row_cnt <= row_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DLY; i++) begin
                sync_d[i] <= '0;
            end
        end else begin
            sync_d[0] <= pre_sync;
            for (int i = 1; i < SYNC_DLY; i++) begin
                sync_d[i] <= sync_d[i-1];
            end
        end
    end

    assign post_hsync = sync_d[SYNC_DLY-1].hs;
    assign post_vsync = sync_d[SYNC_DLY-1].vs;
    assign post_de    = sync_d[SYNC_DLY-1].de;

    // Buffer 2 takes buffer 1's old word one cycle later, same address.
    line_buffer #(
        .DEPTH (H_DISP),
        .DW    (DW),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (pre_de),
        .waddr (col_eff),
        .wdata (pre_data),
        .raddr (col_eff),
        .rdata (rd1)
    );

    line_buffer #(
        .DEPTH (H_DISP),
        .DW    (DW),
        .AW    (CW)
    ) u_lb2 (
        .clk   (clk),
        .we    (sync_d[0].de),
        .waddr (addr_d1),
        .wdata (rd1),
        .raddr (col_eff),
        .rdata (rd2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_d1  <= '0;
            addr_d1  <= '0;
            first_d1 <= 1'b0;
            mask1_d1 <= 1'b0;
            mask2_d1 <= 1'b0;
        end else begin
            data_d1  <= pre_data;
            addr_d1  <= col_eff;
            first_d1 <= line_start;
            mask1_d1 <= (row_eff <= RW'(1));
            mask2_d1 <= (row_eff == '0);
        end
    end

    always_comb begin
        col_new[0] = mask1_d1 ? '0 : rd2;
        col_new[1] = mask2_d1 ? '0 : rd1;
        col_new[2] = data_d1;
    end

    // First pixel of a line shifts zeros into the two older columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN_N; i++) begin
                for (int j = 0; j < WIN_N; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (sync_d[0].de) begin
            for (int i = 0; i < WIN_N; i++) begin
                win[i][0] <= first_d1 ? '0 : win[i][1];
                win[i][1] <= first_d1 ? '0 : win[i][2];
                win[i][2] <= col_new[i];
            end
        end
    end

    assign m11 = win[0][0];
    assign m12 = win[0][1];
    assign m13 = win[0][2];
    assign m21 = win[1][0];
    assign m22 = win[1][1];
    assign m23 = win[1][2];
    assign m31 = win[2][0];
    assign m32 = win[2][1];
    assign m33 = win[2][2];

endmodule

// File: doc/matrix_3x3_gen.md
MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

Interface
REQ-001 Parameter H_DISP, default 500, active pixels per line.
REQ-002 Parameter V_DISP, default 500, active lines per frame.
REQ-003 Parameter DW, default 8, pixel width in bits.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 pre_hsync, pre_vsync, pre_de  input  1 each  upstream raster syncs; vsync active-high.
REQ-007 pre_data  input  DW  upstream pixel, valid when pre_de=1.
REQ-008 post_hsync, post_vsync, post_de  output  1 each  syncs delayed to match the window.
REQ-009 m11..m13, m21..m23, m31..m33  output  DW each  3x3 window; row 1 oldest line, column 1 oldest pixel, m33 newest.

Function
REQ-010 The block SHALL consume a raster stream and emit, for every input pixel with pre_de=1, exactly one window with post_de=1.
REQ-011 For input pixel P(r,c) at cycle t, the window at t+2 SHALL be m[i][j] = P(r-3+i, c-3+j), i,j in 1..3.
REQ-012 Any window element with row index <0 or column index <0 SHALL read as 0.
REQ-013 Latency SHALL be fixed at 2 clocks; post_hsync/post_vsync/post_de SHALL equal the inputs delayed 2 clocks.
REQ-014 col_cnt SHALL increment on each pre_de=1 cycle, hold at H_DISP-1 on overrun, and clear on pre_de falling edge.
REQ-015 row_cnt SHALL increment on each pre_de falling edge, saturate at V_DISP-1, and clear on pre_vsync rising edge.
REQ-016 Two line buffers, depth H_DISP, SHALL hold lines r-1 and r-2, addressed by col_cnt; written only when pre_de=1 (line r into buffer 1, buffer 1 contents into buffer 2, same address, same cycle).
REQ-017 Read-before-write SHALL apply: a read and write to the same address in one cycle returns the old contents.
REQ-018 Rows 1 and 2 of the window SHALL be forced to 0 while row_cnt<2 and <1 respectively, regardless of RAM contents.
REQ-019 Window shift registers SHALL shift only on the delayed de; when delayed de=0 window outputs SHALL hold.
REQ-020 On pre_de rising edge the column shift registers SHALL be cleared so column 1/2 of a new line read 0.
REQ-021 pre_vsync rising edge coincident with pre_de=1 SHALL treat the pixel as row 0, column 0.
REQ-022 Lines shorter than H_DISP SHALL be accepted; unwritten addresses keep prior contents.

Reset
REQ-023 While rst=1: all post_* syncs 0, all m outputs 0, col_cnt=0, row_cnt=0, delay pipeline cleared.
REQ-024 Line-buffer RAM contents SHALL NOT require reset; REQ-018 masking guarantees zeros after reset.
REQ-025 Reset asserted mid-frame SHALL abort the frame; output resumes correctly from the next pre_vsync rising edge.

Structure
REQ-026 Sync delay depth (2) and counter widths derived via clog2 of H_DISP/V_DISP SHALL live in a shared image-pipeline package.
REQ-027 One sub-module, line_buffer (simple dual-port RAM, depth H_DISP, width DW, registered read), SHALL be instantiated twice.
REQ-028 Target 150-300 lines RTL; no vendor IP.

Verification
REQ-029 Reset held 20 clocks, then 4x4 frame (H_DISP=V_DISP=4) with P(r,c)=16r+c -> exactly 16 post_de pulses; window for P(2,2) = {00,01,02;10,11,12;20,21,22} hex.
REQ-030 Same frame -> window for P(0,0) all zero except m33=00; for P(1,0): m13=00, m33=10, rest 0.
REQ-031 pre_hsync/pre_vsync/pre_de toggled arbitrarily -> post versions identical waveform shifted exactly 2 clocks.
REQ-032 Second frame after vsync with P=0xFF -> first two window rows zero on row 0, no leakage of frame-1 data.
REQ-033 rst asserted mid-line 2, released, new frame -> outputs 0 during reset; new frame windows match REQ-011 exactly.
REQ-034 500x500 frame from file, 250000 post_de counted, windows dumped and compared against a software model bit-exact.
